// File: rtl/dht11_poll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dht11_poll_ctrl
// Description : Polling scheduler for the DHT11 single-wire reader. Kicks the
//               reader periodically or on request, watchdogs each transaction,
//               validates the frame checksum, retries failures and publishes
//               the last good humidity/temperature with valid/strobe/fault.
//               Optional macro DHT_ERR_STATS_EN adds saturating error counters
//               (err_cksum_o, err_timeout_o).
// Revision    : 1.0 - initial release
// ============================================================================
module dht11_poll_ctrl #(
  parameter int unsigned CLK_FREQ   = 12_000_000,
  parameter int unsigned POLL_MS    = 2000,
  parameter int unsigned MIN_GAP_MS = 1000,
  parameter int unsigned TIMEOUT_MS = 25,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic        trig_i,
  output logic        rd_start_o,
  input  logic        rd_done_i,
  input  logic [39:0] rd_data_i,
  output logic [7:0]  humidity_o,
  output logic [7:0]  temperature_o,
  output logic        data_valid_o,
  output logic        sample_stb_o,
  output logic        fault_o,
`ifdef DHT_ERR_STATS_EN
  output logic [7:0]  err_cksum_o,
  output logic [7:0]  err_timeout_o,
`endif
  output logic        busy_o
);

  localparam int unsigned MS       = CLK_FREQ / 1000;
  localparam logic [31:0] POLL_CYC = 32'(POLL_MS * MS);
  localparam logic [31:0] GAP_CYC  = 32'(MIN_GAP_MS * MS);
  localparam logic [31:0] TOUT_CYC = 32'(TIMEOUT_MS * MS);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_KICK  = 3'd2,
    S_BUSY  = 3'd3,
    S_CHECK = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;   // gap/poll age outside a transaction, watchdog inside
  logic        pend_q, pend_d;     // trig waiting to be served
  logic        first_q, first_d;   // no kick issued yet since reset
  logic        force_q, force_d;   // retry kick owed as soon as the gap allows
  logic        tout_q, tout_d;     // current attempt ended by watchdog
  logic [7:0]  retry_q, retry_d;
  logic [39:0] data_q, data_d;
  logic [7:0]  hum_q, hum_d;
  logic [7:0]  tmp_q, tmp_d;
  logic        valid_q, valid_d;
  logic        stb_q, stb_d;
  logic        fault_q, fault_d;

  logic [7:0]  cksum_calc;
  logic        gap_ok, poll_due, tout_hit, frame_good;

  assign cksum_calc = data_q[39:32] + data_q[31:24] + data_q[23:16] + data_q[15:8];
  assign frame_good = !tout_q && (data_q[7:0] == cksum_calc);
  assign gap_ok     = timer_q >= GAP_CYC;
  assign poll_due   = timer_q >= POLL_CYC;
  assign tout_hit   = timer_q >= TOUT_CYC;

  // State and datapath registers; timer preset to "gap elapsed" so the first kick is immediate
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      timer_q <= GAP_CYC;
      pend_q  <= 1'b0;
      first_q <= 1'b1;
      force_q <= 1'b0;
      tout_q  <= 1'b0;
      retry_q <= 8'd0;
      data_q  <= 40'd0;
      hum_q   <= 8'd0;
      tmp_q   <= 8'd0;
      valid_q <= 1'b0;
      stb_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      first_q <= first_d;
      force_q <= force_d;
      tout_q  <= tout_d;
      retry_q <= retry_d;
      data_q  <= data_d;
      hum_q   <= hum_d;
      tmp_q   <= tmp_d;
      valid_q <= valid_d;
      stb_q   <= stb_d;
      fault_q <= fault_d;
    end
  end

  // Sequencer: kick scheduling, watchdog, checksum verdict and retry bookkeeping
  always_comb begin
    state_d = state_q;
    timer_d = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;
    pend_d  = pend_q | trig_i;
    first_d = first_q;
    force_d = force_q;
    tout_d  = tout_q;
    retry_d = retry_q;
    data_d  = data_q;
    hum_d   = hum_q;
    tmp_d   = tmp_q;
    valid_d = valid_q;
    stb_d   = 1'b0;
    fault_d = fault_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable_i || trig_i || pend_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (gap_ok && (pend_q || trig_i || poll_due || first_q || force_q)) begin
          state_d = S_KICK;
          pend_d  = 1'b0;
          first_d = 1'b0;
          force_d = 1'b0;
        end else if (!enable_i && !pend_q && !trig_i && !force_q) begin
          state_d = S_IDLE;
        end
      end
      S_KICK: begin
        // timer now counts cycles since rd_start
        timer_d = 32'd1;
        tout_d  = 1'b0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        // a frame arriving on the watchdog's last cycle is still accepted
        if (rd_done_i) begin
          data_d  = rd_data_i;
          state_d = S_CHECK;
        end else if (tout_hit) begin
          tout_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // timer now counts cycles since the transaction ended
        timer_d = 32'd1;
        state_d = S_WAIT;
        if (frame_good) begin
          hum_d   = data_q[39:32];
          tmp_d   = data_q[23:16];
          valid_d = 1'b1;
          stb_d   = 1'b1;
          fault_d = 1'b0;
          retry_d = 8'd0;
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 8'd1;
          force_d = 1'b1;
        end else begin
          fault_d = 1'b1;
          retry_d = 8'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef DHT_ERR_STATS_EN
  logic [7:0] ecks_q, etout_q;

  // Saturating per-cause failure counters, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ecks_q  <= 8'd0;
      etout_q <= 8'd0;
    end else if (state_q == S_CHECK && !frame_good) begin
      if (tout_q) begin
        if (etout_q != 8'hFF) etout_q <= etout_q + 8'd1;
      end else begin
        if (ecks_q != 8'hFF) ecks_q <= ecks_q + 8'd1;
      end
    end
  end

  assign err_cksum_o   = ecks_q;
  assign err_timeout_o = etout_q;
`else
  // error statistics not built in this configuration
`endif

  assign rd_start_o    = (state_q == S_KICK);
  assign busy_o        = (state_q == S_KICK) || (state_q == S_BUSY) || (state_q == S_CHECK);
  assign humidity_o    = hum_q;
  assign temperature_o = tmp_q;
  assign data_valid_o  = valid_q;
  assign sample_stb_o  = stb_q;
  assign fault_o       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_dht11_poll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dht11_poll_ctrl
// Description : Self-checking bench for dht11_poll_ctrl with a scripted reader
//               model and a scoreboard of expected published samples.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dht11_poll_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, enable, trig, rd_done;
  logic [39:0] rd_data;
  logic        rd_start, data_valid, sample_stb, fault, busy;
  logic [7:0]  humidity, temperature;
`ifdef DHT_ERR_STATS_EN
  logic [7:0]  err_cksum, err_timeout;
`endif

  dht11_poll_ctrl #(
    .CLK_FREQ(1000), .POLL_MS(20), .MIN_GAP_MS(10), .TIMEOUT_MS(5), .MAX_RETRY(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .trig_i(trig),
    .rd_start_o(rd_start), .rd_done_i(rd_done), .rd_data_i(rd_data),
    .humidity_o(humidity), .temperature_o(temperature),
    .data_valid_o(data_valid), .sample_stb_o(sample_stb), .fault_o(fault),
`ifdef DHT_ERR_STATS_EN
    .err_cksum_o(err_cksum), .err_timeout_o(err_timeout),
`endif
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] h;
    logic [7:0] t;
    int         c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0, bad = 0, nstart = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic frame_ok(input logic [39:0] d);
    logic [7:0] s;
    s = d[39:32] + d[31:24] + d[23:16] + d[15:8];
    return s == d[7:0];
  endfunction

  // Count kicks and check every published sample against the scoreboard
  always @(negedge clk) begin
    if (rd_start) nstart++;
    if (sample_stb) begin
      if (sb.size() == 0) begin
        chk("stb_unexpected", 64'(1), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("stb_hum", 64'(humidity), 64'(mon_e.h));
        chk("stb_tmp", 64'(temperature), 64'(mon_e.t));
        chk("stb_latency", 64'(cyc), 64'(mon_e.c));
      end
    end
  end

  task automatic wait_start(input int budget, output int k);
    int n;
    k = -1;
    n = 0;
    while (k < 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (rd_start) k = cyc;
    end
    if (k < 0) chk("start_timeout", 64'(0), 64'(1));
  endtask

  task automatic answer(input int k, input int lat, input logic [39:0] dat, output int dn);
    exp_t e;
    while (cyc < k + lat) @(negedge clk);
    rd_data = dat;
    rd_done = 1'b1;
    dn = cyc;
    if (frame_ok(dat)) begin
      e.h = dat[39:32];
      e.t = dat[23:16];
      e.c = cyc + 2;
      sb.push_back(e);
    end
    @(negedge clk);
    rd_done = 1'b0;
  endtask

  initial begin
    int k, d, c, n0, ek;
    rst_n = 1'b0; enable = 1'b0; trig = 1'b0; rd_done = 1'b0; rd_data = 40'd0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", 64'({rd_start, busy, data_valid, sample_stb, fault, humidity, temperature}), 64'(0));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_kick", 64'(nstart), 64'(0));

    // first kick immediate, good frame, then one poll period
    enable = 1'b1;
    c = cyc;
    wait_start(10, k);
    chk("t1_first_kick", 64'(k), 64'(c + 2));
    answer(k, 3, 40'h3C_00_19_00_55, d);
    repeat (2) @(negedge clk);
    chk("t1_humidity", 64'(humidity), 64'(8'h3C));
    chk("t1_temperature", 64'(temperature), 64'(8'h19));
    chk("t1_valid", 64'(data_valid), 64'(1));
    wait_start(40, k);
    chk("t1_poll_period", 64'(k), 64'(d + 22));
    answer(k, 4, 40'h2A_05_1A_03_4C, d);

    // three bad checksums: retries at minimum gap, then fault with outputs held
    ek = d + 22;
    for (int i = 0; i < 3; i++) begin
      wait_start(40, k);
      chk("t2_attempt_kick", 64'(k), 64'(ek));
      answer(k, 2, 40'h3C_00_19_00_54, d);
      ek = d + 12;
    end
    wait_start(40, k);
    chk("t2_poll_after_fault", 64'(k), 64'(d + 22));
    chk("t2_fault", 64'(fault), 64'(1));
    chk("t2_hum_held", 64'(humidity), 64'(8'h2A));
    chk("t2_tmp_held", 64'(temperature), 64'(8'h1A));
    chk("t2_valid_held", 64'(data_valid), 64'(1));
    answer(k, 3, 40'h4B_00_1E_00_69, d);
    repeat (2) @(negedge clk);
    chk("t2_fault_cleared", 64'(fault), 64'(0));

    // reader never answers: watchdog after 5 cycles each attempt
    ek = d + 22;
    for (int i = 0; i < 3; i++) begin
      wait_start(40, k);
      chk("t3_attempt_kick", 64'(k), 64'(ek));
      ek = k + 17;
    end
    wait_start(40, c);
    chk("t3_poll_after_fault", 64'(c), 64'(k + 27));
    chk("t3_fault", 64'(fault), 64'(1));
`ifdef DHT_ERR_STATS_EN
    chk("t3_err_timeout", 64'(err_timeout), 64'(3));
    chk("t2_err_cksum", 64'(err_cksum), 64'(3));
`endif
    answer(c, 3, 40'h1E_00_14_00_32, d);

    // trig 3 cycles into the gap is deferred to gap cycle 10
    while (cyc < d + 5) @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_start(30, k);
    chk("t4_trig_deferred", 64'(k), 64'(d + 12));
    answer(k, 2, 40'h28_00_17_00_3F, d);

    // enable dropped mid-transaction: frame still published, then no more kicks
    wait_start(40, k);
    chk("t5_poll_kick", 64'(k), 64'(d + 22));
    enable = 1'b0;
    answer(k, 3, 40'h32_00_16_00_48, d);
    n0 = nstart;
    repeat (40) @(negedge clk);
    chk("t5_no_more_kicks", 64'(nstart), 64'(n0));
    chk("t5_not_busy", 64'(busy), 64'(0));
    chk("t5_hum", 64'(humidity), 64'(8'h32));

    // trig with gap long elapsed: kick right after WAIT entry
    trig = 1'b1;
    c = cyc;
    @(negedge clk);
    trig = 1'b0;
    wait_start(10, k);
    chk("t4_trig_immediate", 64'(k), 64'(c + 2));
    answer(k, 2, 40'h37_01_18_02_52, d);

    // reset in the middle of a transaction
    repeat (2) @(negedge clk);
    enable = 1'b1;
    wait_start(40, k);
    chk("t6_poll_kick", 64'(k), 64'(d + 22));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outputs", 64'({rd_start, busy, data_valid, sample_stb, fault, humidity, temperature}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    c = cyc;
    wait_start(10, k);
    chk("t6_first_kick_after_rst", 64'(k), 64'(c + 2));
    chk("t6_valid_cleared", 64'(data_valid), 64'(0));
    answer(k, 3, 40'h3C_00_19_00_55, d);
    repeat (3) @(negedge clk);
    chk("t6_valid_again", 64'(data_valid), 64'(1));
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
